ex_unit: RTL and testbench

Integer execution stage directly downstream of the reservation station. Takes at most one ready instruction per cycle from the RS dispatch port and computes the ALU, branch or jump result. Broadcasts the result, tagged with its ROB position, on the EX result bus consumed by the RS, LSB and ROB. With the M extension compiled in, it also runs a multi-cycle divider and back-pressures the RS while it is busy.

---
 rtl/ex_unit_if.sv | 35 +++
 rtl/ex_unit.sv | 200 ++++++++++++++++++++
 tb/tb_ex_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_unit_if.sv
// rtl/ex_unit_if.sv - RS dispatch and EX result bus bundle for ex_unit
interface ex_unit_if;
  localparam int InstrIdWidth = 6;
  localparam int ImmWidth     = 32;
  localparam int WordWidth    = 32;
  localparam int AddrWidth    = 32;
  localparam int ROBIdxWidth  = 4;

  logic                    rs_to_ex_en_in;
  logic [InstrIdWidth-1:0] instr_id_in;
  logic [ImmWidth-1:0]     imm_in;
  logic [WordWidth-1:0]    rs1_in;
  logic [WordWidth-1:0]    rs2_in;
  logic [AddrWidth-1:0]    pc_in;
  logic [ROBIdxWidth-1:0]  rob_pos_in;
  logic                    clear_branch_in;
  logic                    ex_to_rs_en_out;
  logic [ROBIdxWidth-1:0]  ex_to_rs_rob_pos_out;
  logic [WordWidth-1:0]    ex_to_rs_res_out;
  logic                    ex_br_taken_out;
  logic [AddrWidth-1:0]    ex_br_target_out;
  logic                    ex_busy_out;

  modport master (
    output rs_to_ex_en_in, instr_id_in, imm_in, rs1_in, rs2_in, pc_in, rob_pos_in, clear_branch_in,
    input  ex_to_rs_en_out, ex_to_rs_rob_pos_out, ex_to_rs_res_out, ex_br_taken_out,
           ex_br_target_out, ex_busy_out
  );

  modport slave (
    input  rs_to_ex_en_in, instr_id_in, imm_in, rs1_in, rs2_in, pc_in, rob_pos_in, clear_branch_in,
    output ex_to_rs_en_out, ex_to_rs_rob_pos_out, ex_to_rs_res_out, ex_br_taken_out,
           ex_br_target_out, ex_busy_out
  );
endinterface

// File: rtl/ex_unit.sv
// rtl/ex_unit.sv - integer execute stage: ALU/branch/jump, optional M extension (EX_MULDIV_EN)
// Single-cycle results are registered; divides run a 33-cycle restoring FSM when EX_MULDIV_EN is set.
module ex_unit (
  input logic      clk_in,
  input logic      rst_in,
  input logic      rdy_in,
  ex_unit_if.slave bus
);
  localparam int InstrIdWidth = 6;
  localparam int ImmWidth     = 32;
  localparam int WordWidth    = 32;
  localparam int AddrWidth    = 32;
  localparam int ROBIdxWidth  = 4;

  typedef logic [InstrIdWidth-1:0] op_t;
  localparam op_t OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4;
  localparam op_t OP_BEQ  = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8;
  localparam op_t OP_BLTU = 6'd9,  OP_BGEU  = 6'd10, OP_ADDI  = 6'd11, OP_SLTI  = 6'd12;
  localparam op_t OP_SLTIU = 6'd13, OP_XORI = 6'd14, OP_ORI   = 6'd15, OP_ANDI  = 6'd16;
  localparam op_t OP_SLLI = 6'd17, OP_SRLI  = 6'd18, OP_SRAI  = 6'd19, OP_ADD   = 6'd20;
  localparam op_t OP_SUB  = 6'd21, OP_SLL   = 6'd22, OP_SLT   = 6'd23, OP_SLTU  = 6'd24;
  localparam op_t OP_XOR  = 6'd25, OP_SRL   = 6'd26, OP_SRA   = 6'd27, OP_OR    = 6'd28;
  localparam op_t OP_AND  = 6'd29, OP_MUL   = 6'd30, OP_MULH  = 6'd31, OP_MULHSU = 6'd32;
  localparam op_t OP_MULHU = 6'd33, OP_DIV  = 6'd34, OP_DIVU  = 6'd35, OP_REM   = 6'd36;
  localparam op_t OP_REMU = 6'd37;

  op_t                  op;
  logic [WordWidth-1:0] a, b, imm, res_c;
  logic [AddrWidth-1:0] pc, pc_plus4, pc_plus_imm, jalr_target, target_c;
  logic                 taken_c, accept_single;

  logic                   en, taken;
  logic [ROBIdxWidth-1:0] rob;
  logic [WordWidth-1:0]   res;
  logic [AddrWidth-1:0]   target;

  assign op          = bus.instr_id_in;
  assign a           = bus.rs1_in;
  assign b           = bus.rs2_in;
  assign imm         = WordWidth'(bus.imm_in);
  assign pc          = bus.pc_in;
  assign pc_plus4    = pc + AddrWidth'(4);
  assign pc_plus_imm = pc + AddrWidth'(imm);
  assign jalr_target = AddrWidth'(a + imm) & ~AddrWidth'(1);

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} state_t;
  state_t                 state;
  logic [4:0]             cnt;
  logic [WordWidth-1:0]   dq, dd, dr;
  logic                   neg_q, neg_r, want_rem, busy;
  logic [ROBIdxWidth-1:0] div_rob;
  logic [AddrWidth-1:0]   div_pc;
  logic                   is_div, div_signed, a_neg, b_neg, a_sx, b_sx;
  logic [WordWidth:0]     rr, diff;
  logic [2*WordWidth-1:0] ext_a, ext_b, prod;

  assign a_sx       = (op == OP_MULH) || (op == OP_MULHSU);
  assign b_sx       = (op == OP_MULH);
  assign ext_a      = {{WordWidth{a_sx & a[WordWidth-1]}}, a};
  assign ext_b      = {{WordWidth{b_sx & b[WordWidth-1]}}, b};
  assign prod       = ext_a * ext_b;
  assign is_div     = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  assign div_signed = (op == OP_DIV) || (op == OP_REM);
  assign a_neg      = div_signed & a[WordWidth-1];
  assign b_neg      = div_signed & b[WordWidth-1];
  // One restoring step: shift next dividend bit into the partial remainder and try to subtract.
  assign rr         = {dr, dq[WordWidth-1]};
  assign diff       = rr - {1'b0, dd};
  assign accept_single   = bus.rs_to_ex_en_in & (state == IDLE) & ~is_div;
  assign bus.ex_busy_out = busy;
`else
  assign accept_single   = bus.rs_to_ex_en_in;
  assign bus.ex_busy_out = 1'b0;
`endif

  always_comb begin
    res_c    = '0;
    taken_c  = 1'b0;
    target_c = pc_plus4;
    case (op)
      OP_LUI:            res_c = imm;
      OP_AUIPC:          res_c = WordWidth'(pc_plus_imm);
      OP_JAL, OP_JALR: begin
        res_c   = WordWidth'(pc_plus4);
        taken_c = 1'b1;
      end
      OP_BEQ:            taken_c = (a == b);
      OP_BNE:            taken_c = (a != b);
      OP_BLT:            taken_c = ($signed(a) < $signed(b));
      OP_BGE:            taken_c = ($signed(a) >= $signed(b));
      OP_BLTU:           taken_c = (a < b);
      OP_BGEU:           taken_c = (a >= b);
      OP_ADDI:           res_c = a + imm;
      OP_SLTI:           res_c = WordWidth'($signed(a) < $signed(imm));
      OP_SLTIU:          res_c = WordWidth'(a < imm);
      OP_XORI:           res_c = a ^ imm;
      OP_ORI:            res_c = a | imm;
      OP_ANDI:           res_c = a & imm;
      OP_SLLI:           res_c = a << imm[4:0];
      OP_SRLI:           res_c = a >> imm[4:0];
      OP_SRAI:           res_c = $signed(a) >>> imm[4:0];
      OP_ADD:            res_c = a + b;
      OP_SUB:            res_c = a - b;
      OP_SLL:            res_c = a << b[4:0];
      OP_SLT:            res_c = WordWidth'($signed(a) < $signed(b));
      OP_SLTU:           res_c = WordWidth'(a < b);
      OP_XOR:            res_c = a ^ b;
      OP_SRL:            res_c = a >> b[4:0];
      OP_SRA:            res_c = $signed(a) >>> b[4:0];
      OP_OR:             res_c = a | b;
      OP_AND:            res_c = a & b;
`ifdef EX_MULDIV_EN
      OP_MUL:            res_c = prod[WordWidth-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_c = prod[2*WordWidth-1:WordWidth];
`endif
      default:           ;
    endcase
    if (taken_c) target_c = (op == OP_JALR) ? jalr_target : pc_plus_imm;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      en     <= 1'b0;
      rob    <= '0;
      res    <= '0;
      taken  <= 1'b0;
      target <= '0;
`ifdef EX_MULDIV_EN
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      dq       <= '0;
      dd       <= '0;
      dr       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
      div_rob  <= '0;
      div_pc   <= '0;
`endif
    end else if (rdy_in) begin
      en <= 1'b0;
      if (bus.clear_branch_in) begin
        taken <= 1'b0;
`ifdef EX_MULDIV_EN
        state <= IDLE;
        busy  <= 1'b0;
`endif
      end else begin
        if (accept_single) begin
          en     <= 1'b1;
          rob    <= bus.rob_pos_in;
          res    <= res_c;
          taken  <= taken_c;
          target <= target_c;
        end
`ifdef EX_MULDIV_EN
        case (state)
          IDLE: if (bus.rs_to_ex_en_in && is_div) begin
            state    <= DIV_RUN;
            busy     <= 1'b1;
            cnt      <= 5'd31;
            dq       <= a_neg ? -a : a;
            dd       <= b_neg ? -b : b;
            dr       <= '0;
            neg_q    <= (a_neg ^ b_neg) & (b != '0);
            neg_r    <= a_neg;
            want_rem <= (op == OP_REM) || (op == OP_REMU);
            div_rob  <= bus.rob_pos_in;
            div_pc   <= pc;
          end
          DIV_RUN: begin
            dr <= diff[WordWidth] ? rr[WordWidth-1:0] : diff[WordWidth-1:0];
            dq <= {dq[WordWidth-2:0], ~diff[WordWidth]};
            if (cnt == 5'd0) state <= DIV_DONE;
            else             cnt   <= cnt - 5'd1;
          end
          DIV_DONE: begin
            en     <= 1'b1;
            rob    <= div_rob;
            res    <= want_rem ? (neg_r ? -dr : dr) : (neg_q ? -dq : dq);
            taken  <= 1'b0;
            target <= div_pc + AddrWidth'(4);
            busy   <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
`endif
      end
    end
  end

  assign bus.ex_to_rs_en_out      = en;
  assign bus.ex_to_rs_rob_pos_out = rob;
  assign bus.ex_to_rs_res_out     = res;
  assign bus.ex_br_taken_out      = taken;
  assign bus.ex_br_target_out     = target;
endmodule

// File: tb/tb_ex_unit.sv
// tb/tb_ex_unit.sv - scoreboard bench for ex_unit with a random stimulus stream
`timescale 1ns/1ps
module tb_ex_unit;
  localparam int OP_LUI = 1, OP_AUIPC = 2, OP_JAL = 3, OP_JALR = 4, OP_BEQ = 5, OP_BNE = 6;
  localparam int OP_BLT = 7, OP_BGE = 8, OP_BLTU = 9, OP_BGEU = 10, OP_ADDI = 11, OP_SLTI = 12;
  localparam int OP_SLTIU = 13, OP_XORI = 14, OP_ORI = 15, OP_ANDI = 16, OP_SLLI = 17;
  localparam int OP_SRLI = 18, OP_SRAI = 19, OP_ADD = 20, OP_SUB = 21, OP_SLL = 22, OP_SLT = 23;
  localparam int OP_SLTU = 24, OP_XOR = 25, OP_SRL = 26, OP_SRA = 27, OP_OR = 28, OP_AND = 29;
  localparam int OP_MUL = 30, OP_MULH = 31, OP_MULHSU = 32, OP_MULHU = 33;
  localparam int OP_DIV = 34, OP_DIVU = 35, OP_REM = 36, OP_REMU = 37;

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] res;
    logic        taken;
    logic [31:0] target;
    int          at;
  } exp_t;

  logic clk = 0, rst_n = 1, rdy = 1;
  int   cyc = 0, checks = 0, errors = 0;
  bit   rdy_last = 0;
  exp_t sbq[$];

  ex_unit_if bus();
  ex_unit dut (.clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    rdy_last = rdy;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_div(int op);
`ifdef EX_MULDIV_EN
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t model(int op, logic [31:0] a, logic [31:0] b, logic [31:0] imm, logic [31:0] pc);
    exp_t e;
    longint sa = $signed(a), sb = $signed(b), si = $signed(imm);
    longint unsigned ua = a, ub = b, ui = imm;
    int sh_i = int'(imm[4:0]), sh_r = int'(b[4:0]);
    e.rob = 0; e.res = 0; e.taken = 0; e.target = pc + 4; e.at = 0;
    case (op)
      OP_LUI:   e.res = imm;
      OP_AUIPC: e.res = pc + imm;
      OP_JAL:   begin e.res = pc + 4; e.taken = 1; end
      OP_JALR:  begin e.res = pc + 4; e.taken = 1; end
      OP_BEQ:   e.taken = (ua == ub);
      OP_BNE:   e.taken = (ua != ub);
      OP_BLT:   e.taken = (sa < sb);
      OP_BGE:   e.taken = (sa >= sb);
      OP_BLTU:  e.taken = (ua < ub);
      OP_BGEU:  e.taken = (ua >= ub);
      OP_ADDI:  e.res = 32'(sa + si);
      OP_SLTI:  e.res = (sa < si) ? 1 : 0;
      OP_SLTIU: e.res = (ua < ui) ? 1 : 0;
      OP_XORI:  e.res = a ^ imm;
      OP_ORI:   e.res = a | imm;
      OP_ANDI:  e.res = a & imm;
      OP_SLLI:  e.res = 32'(ua * (64'd1 << sh_i));
      OP_SRLI:  e.res = 32'(ua / (64'd1 << sh_i));
      OP_SRAI:  e.res = 32'(sa >>> sh_i);
      OP_ADD:   e.res = 32'(sa + sb);
      OP_SUB:   e.res = 32'(sa - sb);
      OP_SLL:   e.res = 32'(ua * (64'd1 << sh_r));
      OP_SLT:   e.res = (sa < sb) ? 1 : 0;
      OP_SLTU:  e.res = (ua < ub) ? 1 : 0;
      OP_XOR:   e.res = a ^ b;
      OP_SRL:   e.res = 32'(ua / (64'd1 << sh_r));
      OP_SRA:   e.res = 32'(sa >>> sh_r);
      OP_OR:    e.res = a | b;
      OP_AND:   e.res = a & b;
`ifdef EX_MULDIV_EN
      OP_MUL:    e.res = 32'(sa * sb);
      OP_MULH:   e.res = 32'((sa * sb) >>> 32);
      OP_MULHSU: e.res = 32'((sa * longint'(ub)) >>> 32);
      OP_MULHU:  e.res = 32'((ua * ub) >> 32);
      OP_DIV:    e.res = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
      OP_REM:    e.res = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
      OP_DIVU:   e.res = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      OP_REMU:   e.res = (b == 0) ? a : 32'(ua % ub);
`endif
      default: ;
    endcase
    if (e.taken) e.target = (op == OP_JALR) ? ((a + imm) & 32'hFFFF_FFFE) : pc + imm;
    return e;
  endfunction

  // Monitor: every result pulse seen after an enabled edge consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && rdy_last && bus.ex_to_rs_en_out) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", 32'(bus.ex_to_rs_rob_pos_out), 32'hDEAD);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result_cycle", cyc, e.at);
        chk("rob_tag", 32'(bus.ex_to_rs_rob_pos_out), 32'(e.rob));
        chk("result", bus.ex_to_rs_res_out, e.res);
        chk("taken", 32'(bus.ex_br_taken_out), 32'(e.taken));
        chk("target", bus.ex_br_target_out, e.target);
      end
    end
  end

  always @(posedge clk)
    if (rst_n && rdy && bus.rs_to_ex_en_in) chk("no_dispatch_while_busy", 32'(bus.ex_busy_out), 32'h0);

  task automatic drive(int op, logic [31:0] a, logic [31:0] b, logic [31:0] imm, logic [31:0] pc, logic [3:0] rob);
    bus.rs_to_ex_en_in = 1'b1;
    bus.instr_id_in    = 6'(op);
    bus.rs1_in         = a;
    bus.rs2_in         = b;
    bus.imm_in         = imm;
    bus.pc_in          = pc;
    bus.rob_pos_in     = rob;
  endtask

  task automatic issue(int op, logic [31:0] a, logic [31:0] b, logic [31:0] imm, logic [31:0] pc, logic [3:0] rob);
    exp_t e;
    int   n;
    drive(op, a, b, imm, pc, rob);
    @(posedge clk); #1;
    bus.rs_to_ex_en_in = 1'b0;
    e = model(op, a, b, imm, pc);
    e.rob = rob;
    e.at  = is_div(op) ? cyc + 33 : cyc;
    sbq.push_back(e);
    if (is_div(op)) begin
      n = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.ex_busy_out) n++;
        else break;
      end
      chk("div_busy_cycles", n, 33);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.rs_to_ex_en_in = 0; bus.instr_id_in = 0; bus.imm_in = 0; bus.rs1_in = 0;
    bus.rs2_in = 0; bus.pc_in = 0; bus.rob_pos_in = 0; bus.clear_branch_in = 0;
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_en", 32'(bus.ex_to_rs_en_out), 0);
    chk("reset_rob", 32'(bus.ex_to_rs_rob_pos_out), 0);
    chk("reset_res", bus.ex_to_rs_res_out, 0);
    chk("reset_taken", 32'(bus.ex_br_taken_out), 0);
    chk("reset_target", bus.ex_br_target_out, 0);
    chk("reset_busy", 32'(bus.ex_busy_out), 0);
    rst_n = 1;
    @(posedge clk); #1;

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h200, 4'd3);
    issue(OP_BLT, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h100, 4'd5);
    issue(OP_JALR, 32'h1003, 32'h0, 32'h2, 32'h40, 4'd6);
    issue(OP_SRAI, 32'h8000_0010, 32'h0, 32'h4, 32'h44, 4'd7);
    issue(63, 32'h5, 32'h6, 32'h7, 32'h48, 4'd8);
    @(posedge clk); #1;

`ifdef EX_MULDIV_EN
    issue(OP_DIV, 32'd7, 32'd0, 32'h0, 32'h300, 4'd9);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h304, 4'd10);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h308, 4'd11);
    // Flush lands on E10 of a divide: nothing may come out of it.
    drive(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h400, 4'd12);
    @(posedge clk); #1;
    bus.rs_to_ex_en_in = 0;
    repeat (9) @(posedge clk);
    #1 bus.clear_branch_in = 1;
    @(posedge clk); #1;
    bus.clear_branch_in = 0;
    @(negedge clk);
    chk("flush_busy", 32'(bus.ex_busy_out), 0);
    chk("flush_en", 32'(bus.ex_to_rs_en_out), 0);
    issue(OP_ADD, 32'd40, 32'd2, 32'h0, 32'h500, 4'd13);
`endif

    drive(OP_ADD, 32'd3, 32'd4, 32'h0, 32'h600, 4'd14);
    bus.clear_branch_in = 1;
    @(posedge clk); #1;
    bus.rs_to_ex_en_in = 0;
    bus.clear_branch_in = 0;
    @(negedge clk);
    chk("flush_drops_dispatch", 32'(bus.ex_to_rs_en_out), 0);
    chk("flush_taken", 32'(bus.ex_br_taken_out), 0);

    issue(OP_ADD, 32'd5, 32'd6, 32'h0, 32'h700, 4'd2);
    rdy = 0;
    drive(OP_SUB, 32'd9, 32'd1, 32'h0, 32'h704, 4'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_en_held", 32'(bus.ex_to_rs_en_out), 1);
    chk("stall_res_held", bus.ex_to_rs_res_out, 32'd11);
    chk("stall_rob_held", 32'(bus.ex_to_rs_rob_pos_out), 32'd2);
    bus.rs_to_ex_en_in = 0;
    rdy = 1;
    @(posedge clk); #1;
    chk("stall_release_en", 32'(bus.ex_to_rs_en_out), 0);

    for (int i = 0; i < 150; i++) begin
      int op;
      op = $urandom_range(0, 40);
      issue(op, pick(), pick(), pick(), $urandom & 32'hFFFF_FFFC, 4'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    repeat (2) @(posedge clk);
    #1;

`ifdef EX_MULDIV_EN
    drive(OP_DIV, 32'd1000, 32'd3, 32'h0, 32'h800, 4'd4);
    @(posedge clk); #1;
    bus.rs_to_ex_en_in = 0;
    repeat (5) @(posedge clk);
    #3;
`else
    drive(OP_ADD, 32'd1000, 32'd3, 32'h0, 32'h800, 4'd4);
    @(posedge clk); #1;
    bus.rs_to_ex_en_in = 0;
`endif
    rst_n = 0;
    #1;
    chk("async_reset_en", 32'(bus.ex_to_rs_en_out), 0);
    chk("async_reset_busy", 32'(bus.ex_busy_out), 0);
    chk("async_reset_res", bus.ex_to_rs_res_out, 0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    issue(OP_ADD, 32'd1, 32'd1, 32'h0, 32'h900, 4'd15);
    repeat (40) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
